// File: rtl/fighter_pkg.sv
// Shared types and constants for the fighter animation sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fighter_pkg;

   // Default sprite geometry and sequencing constants
   localparam int SPRITE_W_DEF      = 105;
   localparam int SPRITE_H_DEF      = 180;
   localparam int SCREEN_W_DEF      = 640;
   localparam int START_X_DEF       = 100;
   localparam int FLOOR_Y_DEF       = 260;
   localparam int WALK_STEP_DEF     = 2;
   localparam int FRAME_HOLD_DEF    = 6;
   localparam int WALK_FRAMES_DEF   = 4;
   localparam int ATK_FRAMES_DEF    = 5;
   localparam int ACT_FIRST_DEF     = 2;
   localparam int ACT_LAST_DEF      = 3;
   localparam int RECOVER_TICKS_DEF = 8;
   localparam int ADDR_W_DEF        = 18;

   // Counter widths: hold counter must reach max(FRAME_HOLD, RECOVER_TICKS),
   // frame counter must reach max(WALK_FRAMES, ATK_FRAMES).
   localparam int HOLD_W  = 4;
   localparam int FRAME_W = 3;
   localparam int IDX_W   = 4;

   // Animation state, kept as plain constants so legacy tools see fixed codes
   typedef logic [1:0] anim_state_t;
   localparam anim_state_t ST_IDLE    = 2'd0;
   localparam anim_state_t ST_WALK    = 2'd1;
   localparam anim_state_t ST_ATTACK  = 2'd2;
   localparam anim_state_t ST_RECOVER = 2'd3;

   // First sheet slot of the walk cycle (slot 0 is the idle pose)
   function automatic int walk_base_idx();
      return 1;
   endfunction

   // First sheet slot of the attack sequence, right after the walk cycle
   function automatic int atk_base_idx(input int walk_frames);
      return 1 + walk_frames;
   endfunction

   // Recovery reuses the final attack pose
   function automatic int recover_idx(input int walk_frames, input int atk_frames);
      return walk_frames + atk_frames;
   endfunction

   // Sprite-sheet slot shown for a given state and animation frame
   function automatic logic [IDX_W-1:0] sheet_idx(input anim_state_t      st,
                                                  input logic [FRAME_W-1:0] frame,
                                                  input int               walk_frames,
                                                  input int               atk_frames);
      logic [IDX_W-1:0] idx;
      case (st)
         ST_WALK:    idx = IDX_W'(walk_base_idx() + int'(frame));
         ST_ATTACK:  idx = IDX_W'(atk_base_idx(walk_frames) + int'(frame));
         ST_RECOVER: idx = IDX_W'(recover_idx(walk_frames, atk_frames));
         default:    idx = '0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/anim_frame_timer.sv
// Hold/frame counter pair: advances frame every hold_len ticks, optional wrap over len frames.
// Latency: counters update on the clock edge of a tick; done and frame are combinational.
// Backpressure: none; every tick is counted.
module anim_frame_timer
   import fighter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               tick,
   input  logic [HOLD_W-1:0]  hold_len,
   input  logic [FRAME_W-1:0] len,
   input  logic               wrap_mode,
   output logic [FRAME_W-1:0] frame,
   output logic               done
);

   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               hold_wrap;
   logic               last_frame;

   assign hold_wrap  = (hold_q == (hold_len - HOLD_W'(1)));
   assign last_frame = (frame_q == (len - FRAME_W'(1)));

   // One-shot sequences finish on the tick that would roll past the last frame
   assign done = tick & hold_wrap & last_frame & ~wrap_mode;

   // Frame shown after this edge, so the caller can register it with its state
   assign frame = frame_d;

   // Next counter values: clear wins, otherwise count on tick
   always_comb begin
      hold_d  = hold_q;
      frame_d = frame_q;
      if (clear) begin
         hold_d  = '0;
         frame_d = '0;
      end else if (tick) begin
         if (hold_wrap) begin
            hold_d = '0;
            if (last_frame) begin
               frame_d = '0;
            end else begin
               frame_d = frame_q + FRAME_W'(1);
            end
         end else begin
            hold_d = hold_q + HOLD_W'(1);
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q  <= '0;
         frame_q <= '0;
      end else begin
         hold_q  <= hold_d;
         frame_q <= frame_d;
      end
   end

endmodule

// File: rtl/fighter_anim_ctrl.sv
// Per-frame fighter sequencer: position, facing, animation state, sheet base address, hitbox.
// Latency: all outputs update one vga_clk after frame_tick and hold otherwise.
// Backpressure: none; optional FIGHTER_DEBUG_STEP_EN adds anim_freeze/anim_step tick control.
module fighter_anim_ctrl
   import fighter_pkg::*;
#(
   parameter int SPRITE_W      = SPRITE_W_DEF,
   parameter int SPRITE_H      = SPRITE_H_DEF,
   parameter int SCREEN_W      = SCREEN_W_DEF,
   parameter int START_X       = START_X_DEF,
   parameter int FLOOR_Y       = FLOOR_Y_DEF,
   parameter int WALK_STEP     = WALK_STEP_DEF,
   parameter int FRAME_HOLD    = FRAME_HOLD_DEF,
   parameter int WALK_FRAMES   = WALK_FRAMES_DEF,
   parameter int ATK_FRAMES    = ATK_FRAMES_DEF,
   parameter int ACT_FIRST     = ACT_FIRST_DEF,
   parameter int ACT_LAST      = ACT_LAST_DEF,
   parameter int RECOVER_TICKS = RECOVER_TICKS_DEF,
   parameter int ADDR_W        = ADDR_W_DEF
)(
   input  logic              vga_clk,
   input  logic              Reset,
   input  logic              frame_tick,
`ifdef FIGHTER_DEBUG_STEP_EN
   input  logic              anim_freeze,
   input  logic              anim_step,
`endif
   input  logic              move_left,
   input  logic              move_right,
   input  logic              attack,
   output logic [9:0]        AkumaX,
   output logic [9:0]        AkumaY,
   output logic [ADDR_W-1:0] frame_base,
   output logic              facing_left,
   output logic [1:0]        anim_state,
   output logic              hit_active
);

   localparam logic [9:0] X_MAX  = 10'(SCREEN_W - SPRITE_W);
   localparam logic [9:0] X_STEP = 10'(WALK_STEP);
   // Largest index (WALK_FRAMES+ATK_FRAMES) times SPRITE_W*SPRITE_H must fit in ADDR_W
   localparam logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(SPRITE_W * SPRITE_H);

   anim_state_t         state_q, state_d;
   logic [9:0]          x_q, x_d;
   logic                facing_left_q, facing_left_d;
   logic                atk_pend_q, atk_pend_d;
   logic                attack_prev_q, attack_prev_d;
   logic [ADDR_W-1:0]   frame_base_q, frame_base_d;
   logic                hit_active_q, hit_active_d;

   logic                tick_eff;
   logic                dir_any;
   logic                atk_edge;
   logic                busy;
   logic                atk_seen;

   logic                tmr_clear;
   logic [HOLD_W-1:0]   tmr_hold_len;
   logic [FRAME_W-1:0]  tmr_len;
   logic                tmr_wrap;
   logic [FRAME_W-1:0]  tmr_frame;
   logic                tmr_done;

`ifdef FIGHTER_DEBUG_STEP_EN
   assign tick_eff = (frame_tick & ~anim_freeze) | anim_step;
`else
   assign tick_eff = frame_tick;
`endif

   assign dir_any  = move_left ^ move_right;
   assign atk_edge = attack & ~attack_prev_q;
   assign busy     = (state_q == ST_ATTACK) || (state_q == ST_RECOVER);
   // A press landing on the tick cycle itself still counts for that tick
   assign atk_seen = ~busy & (atk_pend_q | atk_edge);

   // Attack edge capture and pending flag; dropped while attacking/recovering
   always_comb begin
      attack_prev_d = attack;
      if (busy || tick_eff) begin
         atk_pend_d = 1'b0;
      end else begin
         atk_pend_d = atk_pend_q | atk_edge;
      end
   end

   // Per-state timer configuration, chosen by the state being timed
   always_comb begin
      tmr_hold_len = HOLD_W'(FRAME_HOLD);
      tmr_len      = FRAME_W'(WALK_FRAMES);
      tmr_wrap     = 1'b1;
      case (state_q)
         ST_ATTACK: begin
            tmr_len  = FRAME_W'(ATK_FRAMES);
            tmr_wrap = 1'b0;
         end
         ST_RECOVER: begin
            tmr_hold_len = HOLD_W'(RECOVER_TICKS);
            tmr_len      = FRAME_W'(1);
            tmr_wrap     = 1'b0;
         end
         default: begin
         end
      endcase
   end

   // State transitions, evaluated only on a tick
   always_comb begin
      state_d = state_q;
      if (tick_eff) begin
         case (state_q)
            ST_IDLE: begin
               if (atk_seen) begin
                  state_d = ST_ATTACK;
               end else if (dir_any) begin
                  state_d = ST_WALK;
               end
            end
            ST_WALK: begin
               if (atk_seen) begin
                  state_d = ST_ATTACK;
               end else if (!dir_any) begin
                  state_d = ST_IDLE;
               end
            end
            ST_ATTACK: begin
               if (tmr_done) begin
                  state_d = ST_RECOVER;
               end
            end
            default: begin
               if (tmr_done) begin
                  state_d = ST_IDLE;
               end
            end
         endcase
      end
   end

   // Entering any state restarts its animation from frame 0
   assign tmr_clear = tick_eff & (state_d != state_q);

   anim_frame_timer u_timer (
      .clk       (vga_clk),
      .rst       (Reset),
      .clear     (tmr_clear),
      .tick      (tick_eff),
      .hold_len  (tmr_hold_len),
      .len       (tmr_len),
      .wrap_mode (tmr_wrap),
      .frame     (tmr_frame),
      .done      (tmr_done)
   );

   // Walking moves and turns the sprite on every tick spent in (or entering) WALK
   always_comb begin
      x_d           = x_q;
      facing_left_d = facing_left_q;
      if (tick_eff && (state_d == ST_WALK)) begin
         facing_left_d = move_left;
         if (move_left) begin
            x_d = (x_q < X_STEP) ? 10'd0 : (x_q - X_STEP);
         end else begin
            x_d = (x_q >= (X_MAX - X_STEP)) ? X_MAX : (x_q + X_STEP);
         end
      end
   end

   // Sheet address and hitbox follow the post-tick state and frame
   always_comb begin
      frame_base_d = frame_base_q;
      hit_active_d = hit_active_q;
      if (tick_eff) begin
         frame_base_d = ADDR_W'(sheet_idx(state_d, tmr_frame, WALK_FRAMES, ATK_FRAMES))
                        * FRAME_BYTES;
         hit_active_d = (state_d == ST_ATTACK) &&
                        (tmr_frame >= FRAME_W'(ACT_FIRST)) &&
                        (tmr_frame <= FRAME_W'(ACT_LAST));
      end
   end

   // State registers
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         x_q           <= 10'(START_X);
         facing_left_q <= 1'b0;
         atk_pend_q    <= 1'b0;
         attack_prev_q <= 1'b0;
         frame_base_q  <= '0;
         hit_active_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         facing_left_q <= facing_left_d;
         atk_pend_q    <= atk_pend_d;
         attack_prev_q <= attack_prev_d;
         frame_base_q  <= frame_base_d;
         hit_active_q  <= hit_active_d;
      end
   end

   assign AkumaX      = x_q;
   assign AkumaY      = 10'(FLOOR_Y);
   assign frame_base  = frame_base_q;
   assign facing_left = facing_left_q;
   assign anim_state  = state_q;
   assign hit_active  = hit_active_q;

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Bench for fighter_anim_ctrl: directed scenarios plus random stimulus against a tick-count model.
// Expected outputs are queued per tick/reset and checked by an independent monitor.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_fighter_anim_ctrl;

   localparam int FB          = 105 * 180;
   localparam int X_MAXV      = 640 - 105;
   localparam int HOLD        = 6;
   localparam int WALK_FR     = 4;
   localparam int ATK_FR      = 5;
   localparam int RECOV       = 8;

   logic        vga_clk = 1'b0;
   logic        Reset = 1'b0;
   logic        frame_tick = 1'b0;
   logic        move_left = 1'b0;
   logic        move_right = 1'b0;
   logic        attack = 1'b0;
   logic [9:0]  AkumaX;
   logic [9:0]  AkumaY;
   logic [17:0] frame_base;
   logic        facing_left;
   logic [1:0]  anim_state;
   logic        hit_active;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int x;
      int fb;
      int fl;
      int st;
      int hit;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: state 0..3, ticks elapsed since entering it
   int m_st, m_x, m_cnt, m_fl;
   bit m_pend, m_aprev;

   fighter_anim_ctrl dut (
      .vga_clk     (vga_clk),
      .Reset       (Reset),
      .frame_tick  (frame_tick),
      .move_left   (move_left),
      .move_right  (move_right),
      .attack      (attack),
      .AkumaX      (AkumaX),
      .AkumaY      (AkumaY),
      .frame_base  (frame_base),
      .facing_left (facing_left),
      .anim_state  (anim_state),
      .hit_active  (hit_active)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      int   idx;
      int   f;
      f = m_cnt / HOLD;
      case (m_st)
         0:       idx = 0;
         1:       idx = 1 + (f % WALK_FR);
         2:       idx = 1 + WALK_FR + f;
         default: idx = WALK_FR + ATK_FR;
      endcase
      e.x   = m_x;
      e.fb  = idx * FB;
      e.fl  = m_fl;
      e.st  = m_st;
      e.hit = (m_st == 2 && f >= 2 && f <= 3) ? 1 : 0;
      return e;
   endfunction

   function automatic void model_reset();
      m_st = 0; m_x = 100; m_cnt = 0; m_fl = 0; m_pend = 0; m_aprev = 0;
   endfunction

   function automatic void enter(input int st);
      m_st  = st;
      m_cnt = 0;
   endfunction

   function automatic void model_step(input bit tk, input bit l, input bit r, input bit a);
      bit edge_a, busy, seen, dir;
      edge_a  = a & ~m_aprev;
      m_aprev = a;
      busy    = (m_st >= 2);
      seen    = !busy && (m_pend || edge_a);
      if (busy || tk) m_pend = 0;
      else            m_pend = m_pend | edge_a;
      if (tk) begin
         dir = l ^ r;
         case (m_st)
            0: if (seen) enter(2); else if (dir) enter(1); else m_cnt++;
            1: if (seen) enter(2); else if (!dir) enter(0); else m_cnt++;
            2: if (m_cnt == ATK_FR * HOLD - 1) enter(3); else m_cnt++;
            default: if (m_cnt == RECOV - 1) enter(0); else m_cnt++;
         endcase
         if (m_st == 1) begin
            m_fl = l ? 1 : 0;
            if (l) m_x = (m_x < 2) ? 0 : m_x - 2;
            else   m_x = (m_x + 2 > X_MAXV) ? X_MAXV : m_x + 2;
         end
         exp_q.push_back(model_out());
      end
   endfunction

   task automatic drive(input bit rst, input bit tk, input bit l, input bit r, input bit a);
      @(negedge vga_clk);
      Reset = rst; frame_tick = tk; move_left = l; move_right = r; attack = a;
      if (rst) begin
         model_reset();
         exp_q.push_back(model_out());
      end else begin
         model_step(tk, l, r, a);
      end
   endtask

   task automatic tk(input bit l, input bit r);
      drive(0, 1, l, r, 0);
      drive(0, 0, l, r, 0);
   endtask

   // Monitor: every cycle after a tick or reset presents a new output set
   initial begin
      bit   smp;
      exp_t e;
      forever begin
         @(posedge vga_clk);
         smp = Reset | frame_tick;
         #1;
         if (smp) begin
            if (exp_q.size() == 0) begin
               chk("sb_nonempty", 0, 1);
            end else begin
               e = exp_q.pop_front();
               chk("sb_x",     int'(AkumaX),      e.x);
               chk("sb_y",     int'(AkumaY),      260);
               chk("sb_fb",    int'(frame_base),  e.fb);
               chk("sb_face",  int'(facing_left), e.fl);
               chk("sb_state", int'(anim_state),  e.st);
               chk("sb_hit",   int'(hit_active),  e.hit);
            end
         end
      end
   end

   initial begin
      bit l, r, a, rs, t;
      model_reset();

      // Reset and idle
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      repeat (3) tk(0, 0);
      chk("idle_x", int'(AkumaX), 100);
      chk("idle_y", int'(AkumaY), 260);
      chk("idle_fb", int'(frame_base), 0);
      chk("idle_state", int'(anim_state), 0);
      chk("idle_hit", int'(hit_active), 0);

      // Walk right for 10 ticks
      tk(0, 1);
      chk("walk_state", int'(anim_state), 1);
      chk("walk_fb0", int'(frame_base), FB);
      repeat (6) tk(0, 1);
      chk("walk_fb1", int'(frame_base), 2 * FB);
      repeat (3) tk(0, 1);
      chk("walk_x120", int'(AkumaX), 120);
      chk("walk_face_r", int'(facing_left), 0);

      // Right clamp, then walk left down to 1 and into the left clamp
      repeat (220) tk(0, 1);
      chk("clamp_right", int'(AkumaX), X_MAXV);
      repeat (267) tk(1, 0);
      chk("left_x1", int'(AkumaX), 1);
      tk(1, 0);
      chk("left_x0", int'(AkumaX), 0);
      tk(1, 0);
      chk("left_stay0", int'(AkumaX), 0);
      chk("face_left", int'(facing_left), 1);

      // Attack pulse between ticks, full attack and recovery
      tk(0, 0);
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      for (int k = 0; k <= 38; k++) begin
         bit both;
         both = (k >= 31);
         if (k == 33) begin
            drive(0, 0, 1, 1, 1);
            drive(0, 0, 1, 1, 0);
         end
         tk(both, both);
         chk($sformatf("atk_hit_%0d", k), int'(hit_active), (k >= 12 && k <= 23) ? 1 : 0);
         chk($sformatf("atk_state_%0d", k), int'(anim_state), (k < 30) ? 2 : ((k < 38) ? 3 : 0));
      end
      tk(1, 1);
      chk("no_reattack", int'(anim_state), 0);
      chk("recover_x", int'(AkumaX), 0);

      // Reset in the middle of an attack
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      repeat (14) tk(0, 0);
      chk("mid_atk_hit", int'(hit_active), 1);
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      chk("rst_atk_state", int'(anim_state), 0);
      chk("rst_atk_hit", int'(hit_active), 0);

      // Pending attack is discarded by reset
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      tk(0, 0);
      chk("rst_pend_clear", int'(anim_state), 0);

      // Random stimulus
      l = 0; r = 0;
      repeat (6000) begin
         if ($urandom_range(0, 7) == 0) l = ~l;
         if ($urandom_range(0, 7) == 0) r = ~r;
         a  = ($urandom_range(0, 29) == 0);
         rs = ($urandom_range(0, 999) == 0);
         t  = ($urandom_range(0, 2) == 0);
         drive(rs, rs ? 1'b0 : t, l, r, a);
      end

      repeat (3) drive(0, 0, 0, 0, 0);
      chk("sb_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
